// File: rtl/pc_sequencer_pkg.sv
// Shared state codes and constants for the LEGv8 program-counter sequencer.
package pc_sequencer_pkg;

  localparam logic [1:0] PCSEQ_BOOT   = 2'd0;
  localparam logic [1:0] PCSEQ_RUN    = 2'd1;
  localparam logic [1:0] PCSEQ_HALTED = 2'd2;
  localparam logic [1:0] PCSEQ_FAULT  = 2'd3;

  localparam int unsigned PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT   = PCSEQ_BOOT,
    ST_RUN    = PCSEQ_RUN,
    ST_HALTED = PCSEQ_HALTED,
    ST_FAULT  = PCSEQ_FAULT
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_branch_target_calc.sv
// PC-relative branch target: selects imm19/imm26, sign-extends, scales to bytes, adds to pc.
module branch_target_calc #(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              imm_sel,
  input  logic [25:0]       imm26,
  input  logic [18:0]       imm19,
  output logic [ADDR_W-1:0] rel_target
);

  logic [ADDR_W-1:0] off_s;

  // Word offset, sign-extended to full address width.
  always_comb begin
    if (imm_sel) begin
      off_s = {{(ADDR_W-26){imm26[25]}}, imm26};
    end else begin
      off_s = {{(ADDR_W-19){imm19[18]}}, imm19};
    end
  end

  // Wraps modulo 2^ADDR_W by construction.
  assign rel_target = pc + (off_s << 2);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: next-PC selection, boot bubble, stall, HALT and sticky target fault.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                ADDR_W     = 64,
  parameter logic [ADDR_W-1:0] RESET_PC   = 64'h0,
  parameter logic [ADDR_W-1:0] IMEM_LIMIT = 64'h0000_0000_0000_1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              branch_src,
  input  logic              imm_sel,
  input  logic [25:0]       imm26,
  input  logic [18:0]       imm19,
  input  logic              reg_branch,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              stall,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              pc_valid,
  output logic              fault,
  output logic [1:0]        seq_state
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;
  logic              pc_valid_q, pc_valid_d;
  logic [ADDR_W-1:0] rel_target_s;
  logic [ADDR_W-1:0] seq_pc_s;
  logic [ADDR_W-1:0] next_pc_s;
  logic              bad_s;

  branch_target_calc #(.ADDR_W(ADDR_W)) u_btc (
    .pc         (pc_q),
    .imm_sel    (imm_sel),
    .imm26      (imm26),
    .imm19      (imm19),
    .rel_target (rel_target_s)
  );

  assign seq_pc_s = pc_q + ADDR_W'(PC_INCR);

  // Next-PC priority: register branch, then taken relative branch, then sequential.
  always_comb begin
    if (reg_branch) begin
      next_pc_s = reg_target;
    end else if (branch_src) begin
      next_pc_s = rel_target_s;
    end else begin
      next_pc_s = seq_pc_s;
    end
  end

  // Running off the end of instruction memory counts as out-of-range.
  assign bad_s = (next_pc_s[1:0] != 2'b00) || (next_pc_s >= IMEM_LIMIT);

  // Sequencer next-state and PC update; HALTED and FAULT are only left through reset.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stall) begin
          state_d = ST_RUN;
        end else if (halt) begin
          state_d = ST_HALTED;
        end else if (bad_s) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else begin
          pc_d = next_pc_s;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end
      default: begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end
    endcase
    pc_valid_d = (state_d == ST_RUN);
  end

  // State, PC and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      fault_q    <= 1'b0;
      pc_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      pc_valid_q <= pc_valid_d;
    end
  end

  assign pc        = pc_q;
  assign pc_plus4  = seq_pc_s;
  assign pc_valid  = pc_valid_q;
  assign fault     = fault_q;
  assign seq_state = state_q;

endmodule
